pc_fetch: RTL and testbench

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/pc_fetch_pkg.sv | 31 +++
 rtl/pc_next_mux.sv | 31 +++
 rtl/pc_fetch.sv | 113 +++++++++++
 tb/tb_pc_fetch.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared encodings, vectors and helpers for the fetch stage.
package pc_fetch_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned JIDX_W = 26;
  localparam int unsigned SRC_W  = 3;

  typedef enum logic [SRC_W-1:0] {
    PCSRC_SEQ    = 3'd0,
    PCSRC_BRANCH = 3'd1,
    PCSRC_JUMP   = 3'd2,
    PCSRC_JR     = 3'd3,
    PCSRC_IRQ    = 3'd4,
    PCSRC_EXC    = 3'd5
  } pc_src_e;

  localparam logic [XLEN-1:0] RESET_VEC = 32'h8000_0000;
  localparam logic [XLEN-1:0] IRQ_VEC   = 32'h8000_0004;
  localparam logic [XLEN-1:0] EXC_VEC   = 32'h8000_0008;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_EXEC  = 1'b1
  } fetch_state_e;

  // Increment that preserves the kernel bit and wraps within the low 31 bits.
  function automatic logic [XLEN-1:0] pc_inc4(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1], pc[XLEN-2:0] + (XLEN-1)'(4)};
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection for the fetch stage.
module pc_next_mux
  import pc_fetch_pkg::*;
(
  input  logic              pc_kernel,
  input  logic [XLEN-1:0]   pc_plus4,
  input  logic [SRC_W-1:0]  pc_src,
  input  logic              branch_taken,
  input  logic [XLEN-1:0]   branch_imm,
  input  logic [JIDX_W-1:0] jump_index,
  input  logic [XLEN-1:0]   jr_target,
  output logic [XLEN-1:0]   next_pc_c
);

  logic [XLEN-1:0] w_branch_sum;

  assign w_branch_sum = pc_plus4 + (branch_imm << 2);

  always_comb begin
    next_pc_c = EXC_VEC;
    case (pc_src)
      PCSRC_SEQ:    next_pc_c = pc_plus4;
      PCSRC_BRANCH: next_pc_c = branch_taken ? {pc_kernel, w_branch_sum[XLEN-2:0]} : pc_plus4;
      PCSRC_JUMP:   next_pc_c = {pc_plus4[XLEN-1:XLEN-4], jump_index, 2'b00};
      PCSRC_JR:     next_pc_c = jr_target;
      PCSRC_IRQ:    next_pc_c = IRQ_VEC;
      default:      next_pc_c = EXC_VEC;
    endcase
  end

endmodule

// File: rtl/pc_fetch.sv
// Two-state fetch/execute sequencer holding the PC, instruction and interrupt pending flag.
module pc_fetch
  import pc_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [SRC_W-1:0]  pc_src,
  input  logic              branch_taken,
  input  logic [XLEN-1:0]   branch_imm,
  input  logic [JIDX_W-1:0] jump_index,
  input  logic [XLEN-1:0]   jr_target,
  input  logic              stall,
  input  logic              irq_in,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [XLEN-1:0]   imem_rdata,
  output logic [XLEN-1:0]   instr,
  output logic              instr_valid,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   pc_plus4,
  output logic              irq_out
);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_plus4;
  logic [XLEN-1:0] r_instr;
  logic            r_pending;
  logic            r_imem_req;
  logic            r_instr_valid;
  logic            r_irq_out;

  fetch_state_e    w_next_state;
  logic [XLEN-1:0] w_mux_pc;
  logic [XLEN-1:0] w_pc;
  logic [XLEN-1:0] w_instr;
  logic            w_pending;
  logic            w_imem_req;
  logic            w_instr_valid;
  logic            w_irq_out;

  pc_next_mux u_pc_next_mux (
    .pc_kernel    (r_pc[XLEN-1]),
    .pc_plus4     (r_pc_plus4),
    .pc_src       (pc_src),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump_index   (jump_index),
    .jr_target    (jr_target),
    .next_pc_c    (w_mux_pc)
  );

  // Outputs are computed from next-state values so they stay registered yet cycle-exact.
  always_comb begin
    w_next_state = r_state;
    w_pc         = r_pc;
    w_instr      = r_instr;
    w_pending    = r_pending | irq_in;
    case (r_state)
      ST_FETCH: begin
        if (imem_ack && r_imem_req) begin
          w_instr      = imem_rdata;
          w_next_state = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!stall) begin
          w_pc         = w_mux_pc;
          w_next_state = ST_FETCH;
          if (pc_src == SRC_W'(PCSRC_IRQ)) begin
            w_pending = irq_in;
          end
        end
      end
      default: w_next_state = ST_FETCH;
    endcase
    w_imem_req    = (w_next_state == ST_FETCH);
    w_instr_valid = (w_next_state == ST_EXEC);
    w_irq_out     = w_pending & ~w_pc[XLEN-1] & (w_next_state == ST_EXEC);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_FETCH;
      r_pc          <= RESET_VEC;
      r_pc_plus4    <= pc_inc4(RESET_VEC);
      r_instr       <= '0;
      r_pending     <= 1'b0;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_irq_out     <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_pc          <= w_pc;
      r_pc_plus4    <= pc_inc4(w_pc);
      r_instr       <= w_instr;
      r_pending     <= w_pending;
      r_imem_req    <= w_imem_req;
      r_instr_valid <= w_instr_valid;
      r_irq_out     <= w_irq_out;
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign pc          = r_pc;
  assign pc_plus4    = r_pc_plus4;
  assign irq_out     = r_irq_out;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: reset, fetch handshake, next-PC selection, stall and interrupts.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  pc_src;
  logic        branch_taken;
  logic [31:0] branch_imm;
  logic [25:0] jump_index;
  logic [31:0] jr_target;
  logic        stall;
  logic        irq_in;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        irq_out;

  int n_cmp  = 0;
  int n_fail = 0;

  pc_fetch dut (
    .clk          (clk),
    .reset        (reset),
    .pc_src       (pc_src),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump_index   (jump_index),
    .jr_target    (jr_target),
    .stall        (stall),
    .irq_in       (irq_in),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .irq_out      (irq_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Complete one fetch: ack with the given word while in FETCH, landing in EXEC.
  task automatic fetch(input logic [31:0] word);
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
    chk("fetch_valid", 32'(instr_valid), 32'd1);
  endtask

  // From EXEC, jump to an arbitrary target via jr and fetch a word there.
  task automatic goto_pc(input logic [31:0] target);
    stall     = 1'b0;
    pc_src    = 3'd3;
    jr_target = target;
    tick();
    pc_src    = 3'd0;
    fetch(32'h0000_0000);
  endtask

  initial begin
    reset = 1'b1; pc_src = 3'd0; branch_taken = 1'b0; branch_imm = '0;
    jump_index = '0; jr_target = '0; stall = 1'b0; irq_in = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0;
    #1 reset = 1'b0;
    #2;
    chk("rst_pc",    pc, 32'h8000_0000);
    chk("rst_req",   32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0000_0000);
    chk("rst_irq",   32'(irq_out), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("rel_req",  32'(imem_req), 32'd1);
    chk("rel_addr", imem_addr, 32'h8000_0000);
    tick();
    chk("wait_addr", imem_addr, 32'h8000_0000);
    chk("wait_valid", 32'(instr_valid), 32'd0);
    fetch(32'h2008_0005);
    chk("f1_instr", instr, 32'h2008_0005);
    chk("f1_req",   32'(imem_req), 32'd0);
    tick();
    chk("f1_valid_drop", 32'(instr_valid), 32'd0);
    chk("seq_addr", imem_addr, 32'h8000_0004);
    chk("seq_plus4", pc_plus4, 32'h8000_0008);

    // Stall for three cycles, with a stray ack that must be ignored.
    fetch(32'h1111_1111);
    stall = 1'b1;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc",    pc, 32'h8000_0004);
      chk("stall_instr", instr, 32'h1111_1111);
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_req",   32'(imem_req), 32'd0);
    end
    imem_ack = 1'b0;

    goto_pc(32'h0000_0010);
    chk("jr_pc10", pc, 32'h0000_0010);
    chk("plus4_14", pc_plus4, 32'h0000_0014);
    pc_src = 3'd1; branch_taken = 1'b1; branch_imm = 32'hFFFF_FFFE;
    tick();
    chk("br_taken", pc, 32'h0000_000C);
    fetch(32'h0);
    goto_pc(32'h0000_0010);
    pc_src = 3'd1; branch_taken = 1'b0;
    tick();
    chk("br_not_taken", pc, 32'h0000_0014);
    fetch(32'h0);

    goto_pc(32'h8000_0040);
    pc_src = 3'd2; jump_index = 26'h000_0100;
    tick();
    chk("jump", pc, 32'h8000_0400);
    fetch(32'h0);
    pc_src = 3'd3; jr_target = 32'h0000_0200;
    tick();
    chk("jr_user", pc, 32'h0000_0200);
    fetch(32'h0);

    // Increment wraps inside the low 31 bits and leaves the kernel bit alone.
    goto_pc(32'h7FFF_FFFC);
    pc_src = 3'd0;
    tick();
    chk("wrap_user", pc, 32'h0000_0000);
    fetch(32'h0);
    goto_pc(32'hFFFF_FFFC);
    pc_src = 3'd0;
    tick();
    chk("wrap_kernel", pc, 32'h8000_0000);
    fetch(32'h0);
    pc_src = 3'd5;
    tick();
    chk("exc_vec", pc, 32'h8000_0008);
    chk("exc_link", pc_plus4, 32'h8000_000C);
    fetch(32'h0);
    pc_src = 3'd6;
    tick();
    chk("src6_vec", pc, 32'h8000_0008);
    fetch(32'h0);

    // User-mode interrupt: one-cycle pulse latches and survives deassertion.
    goto_pc(32'h0000_0020);
    chk("irq_idle", 32'(irq_out), 32'd0);
    stall = 1'b1; irq_in = 1'b1;
    tick();
    irq_in = 1'b0;
    chk("irq_set", 32'(irq_out), 32'd1);
    tick();
    chk("irq_hold", 32'(irq_out), 32'd1);
    stall = 1'b0; pc_src = 3'd4;
    tick();
    chk("irq_vec", pc, 32'h8000_0004);
    chk("irq_link", pc_plus4, 32'h8000_0008);
    chk("irq_fetch_low", 32'(irq_out), 32'd0);
    pc_src = 3'd0;
    fetch(32'h0);
    goto_pc(32'h0000_0030);
    chk("irq_cleared", 32'(irq_out), 32'd0);

    // Kernel-mode pulse stays masked until the PC returns to user space.
    goto_pc(32'h8000_0020);
    stall = 1'b1; irq_in = 1'b1;
    tick();
    irq_in = 1'b0;
    chk("irq_masked", 32'(irq_out), 32'd0);
    goto_pc(32'h0000_0020);
    chk("irq_unmasked", 32'(irq_out), 32'd1);

    // Service with irq_in high on the same edge: set wins.
    stall = 1'b0; pc_src = 3'd4; irq_in = 1'b1;
    tick();
    irq_in = 1'b0; pc_src = 3'd0;
    fetch(32'h0);
    chk("setwin_kernel", 32'(irq_out), 32'd0);
    goto_pc(32'h0000_0040);
    chk("setwin_user", 32'(irq_out), 32'd1);
    stall = 1'b0; pc_src = 3'd4;
    tick();
    pc_src = 3'd0;
    fetch(32'h0);
    goto_pc(32'h0000_0050);
    chk("setwin_cleared", 32'(irq_out), 32'd0);

    // Reset during a stall takes effect immediately.
    fetch_stall_reset: begin
      stall = 1'b1;
      tick();
      chk("pre_rst_valid", 32'(instr_valid), 32'd1);
      reset = 1'b0;
      #1;
      chk("async_pc",    pc, 32'h8000_0000);
      chk("async_instr", instr, 32'h0000_0000);
      chk("async_valid", 32'(instr_valid), 32'd0);
      chk("async_req",   32'(imem_req), 32'd0);
      tick();
      reset = 1'b1; stall = 1'b0;
      tick();
      chk("rerel_req",  32'(imem_req), 32'd1);
      chk("rerel_addr", imem_addr, 32'h8000_0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
